dbg_ctrl: RTL and testbench
===========================

Name: dbg_ctrl

Overview:
- Debug command responder: host-to-core direction of the simulator debug interface.
- Accepts host commands (halt, resume, single-step, GPR/PC read/write) on a valid/ready request channel and drives core halt control and GPR/PC write ports.
- Returns one response per command on a valid/ready response channel.
- Sits between the simulator-side command source and the core's register file and fetch stage.

Parameters:
- XLEN, 32, data and PC width
- NREG, 32, number of GPRs; addresses >= NREG are illegal
- AW, 5, GPR address width
- HALT_TIMEOUT, 1024, cycles to wait for core_halted before reporting a timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_op  in  3  0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 RD_GPR, 5 WR_GPR, 6 RD_PC, 7 WR_PC
- req_addr  in  AW  GPR index
- req_data  in  XLEN  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_status  out  2  0 OK, 1 ERR_NOT_HALTED, 2 ERR_TIMEOUT, 3 ERR_BAD_ADDR
- rsp_data  out  XLEN  read data / committed PC
- core_halt_req  out  1  stall fetch and drain pipeline
- core_halted  in  1  core is drained and idle
- core_pc  in  XLEN  next PC to execute
- commit_valid  in  1  instruction committed this cycle
- commit_pc  in  XLEN  PC of committed instruction
- brk  in  1  ebreak committed
- gpr_raddr  out  AW  GPR read address; gpr_rdata is combinational
- gpr_rdata  in  XLEN  GPR read data
- gpr_wen  out  1  GPR write enable
- gpr_waddr  out  AW  GPR write address
- gpr_wdata  out  XLEN  GPR write data
- pc_wen  out  1  PC write enable
- pc_wdata  out  XLEN  PC write data
- halted  out  1  controller is in HALTED

Behaviour:
- States: RUN, HALTING, HALTED, STEP_RUN, STEP_HALT, RESP.
- Reset values (also on reset mid-operation):
  - state RUN
  - every output 0, except req_ready=1
  - timer cleared; any pending response is dropped
- req_ready is 1 only in RUN or HALTED with no pending response.
- A command is accepted on the cycle req_valid && req_ready.
- Immediate ops respond with rsp_valid=1 the cycle after acceptance.
- rsp_status/rsp_data hold stable until rsp_ready. The state after the response returns to RUN or HALTED.
- STATUS: OK; rsp_data[0] = halted.
- HALT:
  - In HALTED: OK immediately.
  - In RUN: core_halt_req=1, go to HALTING.
  - On core_halted: respond OK, go to HALTED.
  - If the timer reaches HALT_TIMEOUT first: drop core_halt_req, respond ERR_TIMEOUT, return to RUN.
- RESUME: core_halt_req=0 and respond OK. In RUN this is an OK no-op.
- STEP:
  - In RUN: ERR_NOT_HALTED.
  - In HALTED: drop core_halt_req and go to STEP_RUN.
  - On the first commit_valid, capture commit_pc, reassert core_halt_req in that same cycle, and go to STEP_HALT.
  - On core_halted: respond OK with rsp_data = captured PC, go to HALTED.
  - The timer covers STEP_RUN + STEP_HALT; expiry gives ERR_TIMEOUT and the controller stays halt-requested (HALTED once core_halted).
- RD_GPR / WR_GPR / RD_PC / WR_PC:
  - Not HALTED: ERR_NOT_HALTED, no side effect.
  - req_addr >= NREG: ERR_BAD_ADDR, no write.
- RD_GPR: gpr_raddr = req_addr in the accept cycle; rsp_data registers gpr_rdata.
- WR_GPR: gpr_wen pulses 1 cycle after acceptance.
  - Address 0: gpr_wen is suppressed and the response is still OK.
- RD_PC: rsp_data = core_pc.
- WR_PC: pc_wen pulses 1 cycle; pc_wdata = req_data.
- brk in RUN: core_halt_req=1, go to HALTING without generating a response. On core_halted, go to HALTED.
- brk during STEP_RUN acts as the step's commit.
- brk on the same cycle as an accepted HALT: single halt sequence, one OK response.
- commit_valid while HALTED is ignored.
- Timer is XLEN-independent, width clog2(HALT_TIMEOUT+1), and saturates.

Optional Feature:
- Macro: DBG_HALT_ON_RESET_EN.
- Defined: reset state is HALTING with core_halt_req=1. The controller reaches HALTED on core_halted without a response and with no timeout, so the host can load GPRs/PC before the first instruction.
- Undefined: reset state is RUN as above.

Decomposition:
- Shared package dbg_pkg holds:
  - dbg_op_e (3-bit op codes)
  - dbg_status_e (2-bit)
  - dbg_state_e
  - localparam DBG_REQ_W
- One sub-module, dbg_halt_timer: clear/enable/saturating counter with a done flag at HALT_TIMEOUT.

Test Plan:
- RUN, WR_GPR addr=3 data=0xDEADBEEF -> rsp_status=1 ERR_NOT_HALTED, gpr_wen never asserted.
- HALT with core_halted after 5 cycles -> core_halt_req=1 from cycle 1, rsp OK on cycle 6, halted=1. Then WR_GPR x3=0xDEADBEEF -> gpr_wen 1 cycle at waddr 3; RD_GPR 3 -> rsp_data=0xDEADBEEF.
- Halted, STEP, commit_valid with commit_pc=0x80000004 after 2 cycles -> core_halt_req low for exactly the step window, rsp OK, rsp_data=0x80000004, halted=1.
- HALT with core_halted held 0 -> after HALT_TIMEOUT=1024 cycles rsp_status=2 ERR_TIMEOUT, core_halt_req=0, state RUN.
- Halted, RD_GPR addr=40 with NREG=32 -> ERR_BAD_ADDR. WR_GPR addr=0 -> OK with no gpr_wen. rsp_ready held 0 for 3 cycles -> rsp stable, req_ready=0.
- brk in RUN, then reset low mid-HALTING -> all outputs at reset values.
  - With DBG_HALT_ON_RESET_EN: core_halt_req=1 after reset and halted=1 once core_halted.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types for the debug command responder: op codes, response status, FSM states.
package dbg_pkg;

    typedef enum logic [2:0] {
        OP_STATUS = 3'd0,
        OP_HALT   = 3'd1,
        OP_RESUME = 3'd2,
        OP_STEP   = 3'd3,
        OP_RD_GPR = 3'd4,
        OP_WR_GPR = 3'd5,
        OP_RD_PC  = 3'd6,
        OP_WR_PC  = 3'd7
    } dbg_op_e;

    typedef enum logic [1:0] {
        STS_OK             = 2'd0,
        STS_ERR_NOT_HALTED = 2'd1,
        STS_ERR_TIMEOUT    = 2'd2,
        STS_ERR_BAD_ADDR   = 2'd3
    } dbg_status_e;

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_HALTING   = 3'd1,
        S_HALTED    = 3'd2,
        S_STEP_RUN  = 3'd3,
        S_STEP_HALT = 3'd4,
        S_RESP      = 3'd5
    } dbg_state_e;

    // Request record width at default sizing: op + GPR address + data.
    localparam int unsigned DBG_REQ_W = 3 + 5 + 32;

    // GPR ops are the only ones whose address field is range-checked.
    function automatic logic dbg_is_gpr_op(input dbg_op_e op);
        return (op == OP_RD_GPR) || (op == OP_WR_GPR);
    endfunction

endpackage

// File: rtl/dbg_halt_timer.sv
// Saturating cycle counter bounding how long the controller waits on core_halted.
module dbg_halt_timer
    import dbg_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    // Count while enabled, hold at LIMIT, clear whenever the wait window is not open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(LIMIT))) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/dbg_ctrl.sv
// Debug command responder: host commands in, core halt control and GPR/PC writes out.
// Optional DBG_HALT_ON_RESET_EN: leave reset halt-requested and settle in HALTED silently.
module dbg_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREG         = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned HALT_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [1:0]      rsp_status,
    output logic [XLEN-1:0] rsp_data,
    output logic            core_halt_req,
    input  logic            core_halted,
    input  logic [XLEN-1:0] core_pc,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            brk,
    output logic [AW-1:0]   gpr_raddr,
    input  logic [XLEN-1:0] gpr_rdata,
    output logic            gpr_wen,
    output logic [AW-1:0]   gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata,
    output logic            pc_wen,
    output logic [XLEN-1:0] pc_wdata,
    output logic            halted
);

`ifdef DBG_HALT_ON_RESET_EN
    localparam dbg_state_e RST_STATE = S_HALTING;
    localparam logic       RST_HALT  = 1'b1;
`else
    localparam dbg_state_e RST_STATE = S_RUN;
    localparam logic       RST_HALT  = 1'b0;
`endif

    dbg_state_e      r_state;
    dbg_state_e      r_ret_state;
    dbg_status_e     r_rsp_status;
    logic [XLEN-1:0] r_rsp_data;
    logic [XLEN-1:0] r_step_pc;
    logic [AW-1:0]   r_gpr_waddr;
    logic [XLEN-1:0] r_gpr_wdata;
    logic [XLEN-1:0] r_pc_wdata;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic            r_halt_req;
    logic            r_silent;
    logic            r_halted;
    logic            r_gpr_wen;
    logic            r_pc_wen;

    logic            w_accept;
    logic            w_bad_addr;
    logic            w_commit;
    logic            w_tmr_clr;
    logic            w_tmr_done;
    dbg_op_e         w_op;

    assign w_op       = dbg_op_e'(req_op);
    assign w_accept   = req_valid && r_req_ready;
    assign w_bad_addr = dbg_is_gpr_op(w_op) && (32'(req_addr) >= 32'(NREG));
    assign w_commit   = commit_valid || brk;
    assign w_tmr_clr  = !((r_state == S_HALTING) || (r_state == S_STEP_RUN) ||
                          (r_state == S_STEP_HALT));

    dbg_halt_timer #(
        .LIMIT (HALT_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_tmr_clr),
        .i_en   (!w_tmr_clr),
        .o_done (w_tmr_done)
    );

    // Command FSM; r_silent marks halt sequences that must not produce a response or time out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RST_STATE;
            r_ret_state  <= S_RUN;
            r_rsp_status <= STS_OK;
            r_rsp_data   <= '0;
            r_step_pc    <= '0;
            r_gpr_waddr  <= '0;
            r_gpr_wdata  <= '0;
            r_pc_wdata   <= '0;
            r_req_ready  <= !RST_HALT;
            r_rsp_valid  <= 1'b0;
            r_halt_req   <= RST_HALT;
            r_silent     <= RST_HALT;
            r_halted     <= 1'b0;
            r_gpr_wen    <= 1'b0;
            r_pc_wen     <= 1'b0;
        end else begin
            r_gpr_wen <= 1'b0;
            r_pc_wen  <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_state      <= S_RESP;
                        r_req_ready  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_OK;
                        r_rsp_data   <= '0;
                        r_ret_state  <= brk ? S_HALTING : S_RUN;
                        r_silent     <= brk;
                        r_halt_req   <= brk;
                        case (w_op)
                            OP_STATUS, OP_RESUME: r_rsp_status <= STS_OK;
                            OP_HALT: begin
                                r_state     <= S_HALTING;
                                r_rsp_valid <= 1'b0;
                                r_halt_req  <= 1'b1;
                                r_silent    <= 1'b0;
                            end
                            default: r_rsp_status <= STS_ERR_NOT_HALTED;
                        endcase
                    end else if (brk) begin
                        r_state     <= S_HALTING;
                        r_req_ready <= 1'b0;
                        r_halt_req  <= 1'b1;
                        r_silent    <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_HALTED: begin
                    if (w_accept) begin
                        r_state      <= S_RESP;
                        r_req_ready  <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_OK;
                        r_rsp_data   <= '0;
                        r_ret_state  <= S_HALTED;
                        case (w_op)
                            OP_STATUS: r_rsp_data <= {{(XLEN-1){1'b0}}, 1'b1};
                            OP_HALT:   r_rsp_status <= STS_OK;
                            OP_RESUME: begin
                                r_halt_req  <= 1'b0;
                                r_ret_state <= S_RUN;
                                r_halted    <= 1'b0;
                            end
                            OP_STEP: begin
                                r_state     <= S_STEP_RUN;
                                r_rsp_valid <= 1'b0;
                                r_halt_req  <= 1'b0;
                                r_halted    <= 1'b0;
                            end
                            OP_RD_GPR: begin
                                if (w_bad_addr) r_rsp_status <= STS_ERR_BAD_ADDR;
                                else            r_rsp_data   <= gpr_rdata;
                            end
                            OP_WR_GPR: begin
                                if (w_bad_addr) begin
                                    r_rsp_status <= STS_ERR_BAD_ADDR;
                                end else begin
                                    r_gpr_wen   <= (req_addr != '0);
                                    r_gpr_waddr <= req_addr;
                                    r_gpr_wdata <= req_data;
                                end
                            end
                            OP_RD_PC: r_rsp_data <= core_pc;
                            OP_WR_PC: begin
                                r_pc_wen   <= 1'b1;
                                r_pc_wdata <= req_data;
                            end
                            default: r_rsp_status <= STS_OK;
                        endcase
                    end else begin
                        r_state <= S_HALTED;
                    end
                end
                S_HALTING: begin
                    if (core_halted) begin
                        r_halted <= 1'b1;
                        if (r_silent) begin
                            r_state     <= S_HALTED;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state      <= S_RESP;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_status <= STS_OK;
                            r_rsp_data   <= '0;
                            r_ret_state  <= S_HALTED;
                        end
                    end else if (w_tmr_done && !r_silent) begin
                        r_state      <= S_RESP;
                        r_halt_req   <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_ERR_TIMEOUT;
                        r_rsp_data   <= '0;
                        r_ret_state  <= S_RUN;
                    end else begin
                        r_state <= S_HALTING;
                    end
                end
                S_STEP_RUN: begin
                    if (w_commit) begin
                        r_step_pc  <= commit_pc;
                        r_halt_req <= 1'b1;
                        r_state    <= S_STEP_HALT;
                    end else if (w_tmr_done) begin
                        r_state      <= S_RESP;
                        r_halt_req   <= 1'b1;
                        r_silent     <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_ERR_TIMEOUT;
                        r_rsp_data   <= '0;
                        r_ret_state  <= S_HALTING;
                    end else begin
                        r_state <= S_STEP_RUN;
                    end
                end
                S_STEP_HALT: begin
                    if (core_halted) begin
                        r_state      <= S_RESP;
                        r_halted     <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_OK;
                        r_rsp_data   <= r_step_pc;
                        r_ret_state  <= S_HALTED;
                    end else if (w_tmr_done) begin
                        r_state      <= S_RESP;
                        r_silent     <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= STS_ERR_TIMEOUT;
                        r_rsp_data   <= '0;
                        r_ret_state  <= S_HALTING;
                    end else begin
                        r_state <= S_STEP_HALT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= r_ret_state;
                        r_req_ready <= (r_ret_state == S_RUN) || (r_ret_state == S_HALTED);
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state     <= S_RUN;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_halt_req  <= 1'b0;
                    r_halted    <= 1'b0;
                end
            endcase
        end
    end

    // A step's commit must stop fetch in the commit cycle itself, ahead of the registered request.
    assign core_halt_req = r_halt_req || ((r_state == S_STEP_RUN) && w_commit);
    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_status    = r_rsp_status;
    assign rsp_data      = r_rsp_data;
    assign gpr_raddr     = req_addr;
    assign gpr_wen       = r_gpr_wen;
    assign gpr_waddr     = r_gpr_waddr;
    assign gpr_wdata     = r_gpr_wdata;
    assign pc_wen        = r_pc_wen;
    assign pc_wdata      = r_pc_wdata;
    assign halted        = r_halted;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl: vector table for single commands plus halt/step/timeout/brk sequences.
module tb_dbg_ctrl;
    import dbg_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 6;
    localparam int TMO  = 1024;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0, req_ready;
    logic [2:0]      req_op = 3'd0;
    logic [AW-1:0]   req_addr = '0;
    logic [XLEN-1:0] req_data = '0;
    logic            rsp_valid, rsp_ready = 1'b0;
    logic [1:0]      rsp_status;
    logic [XLEN-1:0] rsp_data;
    logic            core_halt_req, core_halted = 1'b0;
    logic [XLEN-1:0] core_pc = 32'h8000_0000;
    logic            commit_valid = 1'b0, brk = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic [AW-1:0]   gpr_raddr, gpr_waddr;
    logic [XLEN-1:0] gpr_rdata, gpr_wdata, pc_wdata;
    logic            gpr_wen, pc_wen, halted;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;
    int pcw_cnt = 0;
    logic [AW-1:0]   last_waddr = '0;
    logic [XLEN-1:0] last_wdata = '0;
    logic [XLEN-1:0] last_pcw   = '0;
    logic [XLEN-1:0] tb_regs [64];

    dbg_ctrl #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .HALT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data),
        .core_halt_req(core_halt_req), .core_halted(core_halted), .core_pc(core_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .brk(brk),
        .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .pc_wen(pc_wen), .pc_wdata(pc_wdata), .halted(halted)
    );

    always #5 clk = ~clk;

    assign gpr_rdata = tb_regs[gpr_raddr];

    // Register-file / PC stub; write pulses are counted mid-cycle so each one-cycle pulse counts once.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) tb_regs[i] <= '0;
        end else begin
            if (gpr_wen) begin
                tb_regs[gpr_waddr] <= gpr_wdata;
                wen_cnt    <= wen_cnt + 1;
                last_waddr <= gpr_waddr;
                last_wdata <= gpr_wdata;
            end
            if (pc_wen) begin
                pcw_cnt  <= pcw_cnt + 1;
                last_pcw <= pc_wdata;
            end
        end
    end

    typedef struct {
        logic [2:0]      op;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [1:0]      st;
        logic [XLEN-1:0] rd;
        logic            chk_d;
        int              wen;
        int              pcw;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        int n = 0;
        while (!req_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [1:0] st, output logic [XLEN-1:0] d, output int n);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 32'd1);
        st = rsp_status;
        d  = rsp_data;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input int i);
        logic [1:0]      st;
        logic [XLEN-1:0] d;
        int              n, w0, p0;
        w0 = wen_cnt;
        p0 = pcw_cnt;
        send(vt[i].op, vt[i].addr, vt[i].data);
        get_rsp(st, d, n);
        tick();
        chk($sformatf("vec%0d_status", i), 32'(st), 32'(vt[i].st));
        if (vt[i].chk_d) chk($sformatf("vec%0d_data", i), d, vt[i].rd);
        chk($sformatf("vec%0d_gpr_wen", i), 32'(wen_cnt - w0), 32'(vt[i].wen));
        chk($sformatf("vec%0d_pc_wen", i), 32'(pcw_cnt - p0), 32'(vt[i].pcw));
        if (vt[i].wen != 0) begin
            chk($sformatf("vec%0d_waddr", i), 32'(last_waddr), 32'(vt[i].addr));
            chk($sformatf("vec%0d_wdata", i), last_wdata, vt[i].data);
        end
        if (vt[i].pcw != 0) chk($sformatf("vec%0d_pcwdata", i), last_pcw, vt[i].data);
    endtask

    task automatic chk_reset_outputs(input string tag);
`ifdef DBG_HALT_ON_RESET_EN
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_halt_req"}, 32'(core_halt_req), 32'd1);
`else
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_halt_req"}, 32'(core_halt_req), 32'd0);
`endif
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_gpr_wen"}, 32'(gpr_wen), 32'd0);
        chk({tag, "_pc_wen"}, 32'(pc_wen), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        logic [1:0]      st;
        logic [XLEN-1:0] d;
        int              n;

        // Commands issued while running: only STATUS and RESUME succeed.
        vt[0]  = '{3'd0, 6'd0,  32'h0,         2'd0, 32'h0,         1'b1, 0, 0};
        vt[1]  = '{3'd5, 6'd3,  32'hDEADBEEF,  2'd1, 32'h0,         1'b0, 0, 0};
        vt[2]  = '{3'd6, 6'd0,  32'h0,         2'd1, 32'h0,         1'b0, 0, 0};
        vt[3]  = '{3'd3, 6'd0,  32'h0,         2'd1, 32'h0,         1'b0, 0, 0};
        vt[4]  = '{3'd2, 6'd0,  32'h0,         2'd0, 32'h0,         1'b0, 0, 0};
        // Commands issued while halted.
        vt[5]  = '{3'd0, 6'd0,  32'h0,         2'd0, 32'h1,         1'b1, 0, 0};
        vt[6]  = '{3'd5, 6'd3,  32'hDEADBEEF,  2'd0, 32'h0,         1'b0, 1, 0};
        vt[7]  = '{3'd4, 6'd3,  32'h0,         2'd0, 32'hDEADBEEF,  1'b1, 0, 0};
        vt[8]  = '{3'd5, 6'd0,  32'h12345678,  2'd0, 32'h0,         1'b0, 0, 0};
        vt[9]  = '{3'd4, 6'd0,  32'h0,         2'd0, 32'h0,         1'b1, 0, 0};
        vt[10] = '{3'd4, 6'd40, 32'h0,         2'd3, 32'h0,         1'b0, 0, 0};
        vt[11] = '{3'd5, 6'd40, 32'h55,        2'd3, 32'h0,         1'b0, 0, 0};
        vt[12] = '{3'd7, 6'd0,  32'h100,       2'd0, 32'h0,         1'b0, 0, 1};
        vt[13] = '{3'd6, 6'd0,  32'h0,         2'd0, 32'h80000000,  1'b1, 0, 0};
        vt[14] = '{3'd1, 6'd0,  32'h0,         2'd0, 32'h0,         1'b0, 0, 0};
        vt[15] = '{3'd5, 6'd31, 32'hA5A5A5A5,  2'd0, 32'h0,         1'b0, 1, 0};
        vt[16] = '{3'd4, 6'd31, 32'h0,         2'd0, 32'hA5A5A5A5,  1'b1, 0, 0};
        vt[17] = '{3'd4, 6'd32, 32'h0,         2'd3, 32'h0,         1'b0, 0, 0};
        vt[18] = '{3'd5, 6'd32, 32'h77,        2'd3, 32'h0,         1'b0, 0, 0};
        vt[19] = '{3'd0, 6'd0,  32'h0,         2'd0, 32'h1,         1'b1, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick();

`ifdef DBG_HALT_ON_RESET_EN
        core_halted = 1'b1;
        repeat (3) tick();
        chk("hor_halted", 32'(halted), 32'd1);
        chk("hor_no_rsp", 32'(rsp_valid), 32'd0);
        send(3'd2, '0, '0);
        get_rsp(st, d, n);
        core_halted = 1'b0;
        tick();
`endif

        for (int i = 0; i < 5; i++) run_vec(i);
        chk("run_halted", 32'(halted), 32'd0);

        // HALT with core_halted arriving five cycles after acceptance.
        send(3'd1, '0, '0);
        chk("halt_req_c1", 32'(core_halt_req), 32'd1);
        repeat (4) tick();
        chk("halting_no_rsp", 32'(rsp_valid), 32'd0);
        chk("halting_ready", 32'(req_ready), 32'd0);
        core_halted = 1'b1;
        get_rsp(st, d, n);
        chk("halt_status", 32'(st), 32'd0);
        chk("halt_latency", 32'(n), 32'd1);
        chk("halt_halted", 32'(halted), 32'd1);

        for (int i = 5; i < 20; i++) run_vec(i);

        // Response held while the host stalls.
        send(3'd4, 6'd40, '0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_status", k), 32'(rsp_status), 32'd3);
            chk($sformatf("hold%0d_ready", k), 32'(req_ready), 32'd0);
            tick();
        end
        get_rsp(st, d, n);
        chk("hold_final_status", 32'(st), 32'd3);

        // Single step: commit two cycles in, core drains one cycle later.
        send(3'd3, '0, '0);
        chk("step_halt_req_low0", 32'(core_halt_req), 32'd0);
        core_halted = 1'b0;
        tick();
        chk("step_halt_req_low1", 32'(core_halt_req), 32'd0);
        chk("step_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        commit_valid = 1'b1;
        commit_pc    = 32'h8000_0004;
        #1;
        chk("step_commit_halt_req", 32'(core_halt_req), 32'd1);
        tick();
        commit_valid = 1'b0;
        commit_pc    = 32'h0;
        chk("step_after_commit_halt_req", 32'(core_halt_req), 32'd1);
        tick();
        core_halted = 1'b1;
        get_rsp(st, d, n);
        chk("step_status", 32'(st), 32'd0);
        chk("step_pc", d, 32'h8000_0004);
        chk("step_halted", 32'(halted), 32'd1);

        // Commits while halted change nothing.
        commit_valid = 1'b1;
        commit_pc    = 32'h0000_0123;
        repeat (2) tick();
        commit_valid = 1'b0;
        chk("ign_commit_halted", 32'(halted), 32'd1);
        chk("ign_commit_rsp", 32'(rsp_valid), 32'd0);
        chk("ign_commit_halt_req", 32'(core_halt_req), 32'd1);

        // RESUME, then HALT that never completes.
        send(3'd2, '0, '0);
        get_rsp(st, d, n);
        chk("resume_status", 32'(st), 32'd0);
        chk("resume_halt_req", 32'(core_halt_req), 32'd0);
        chk("resume_halted", 32'(halted), 32'd0);
        core_halted = 1'b0;
        send(3'd1, '0, '0);
        get_rsp(st, d, n);
        chk("tmo_status", 32'(st), 32'd2);
        chk("tmo_cycles", 32'(n), 32'd1025);
        chk("tmo_halt_req", 32'(core_halt_req), 32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd1);
        chk("tmo_halted", 32'(halted), 32'd0);

        // brk coinciding with an accepted HALT gives exactly one response.
        chk("hb_ready", 32'(req_ready), 32'd1);
        req_op    = 3'd1;
        req_valid = 1'b1;
        brk       = 1'b1;
        tick();
        req_valid = 1'b0;
        brk       = 1'b0;
        repeat (2) tick();
        core_halted = 1'b1;
        get_rsp(st, d, n);
        chk("hb_status", 32'(st), 32'd0);
        repeat (3) tick();
        chk("hb_no_second_rsp", 32'(rsp_valid), 32'd0);
        chk("hb_halted", 32'(halted), 32'd1);

        send(3'd2, '0, '0);
        get_rsp(st, d, n);
        core_halted = 1'b0;
        tick();

        // brk while running halts silently; reset lands mid-HALTING.
        brk = 1'b1;
        tick();
        brk = 1'b0;
        chk("brk_halt_req", 32'(core_halt_req), 32'd1);
        chk("brk_ready", 32'(req_ready), 32'd0);
        repeat (3) tick();
        chk("brk_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #2;
        chk_reset_outputs("midreset");
        tick();
        reset = 1'b1;
        tick();
`ifdef DBG_HALT_ON_RESET_EN
        core_halted = 1'b1;
        repeat (3) tick();
        chk("hor2_halted", 32'(halted), 32'd1);
        chk("hor2_no_rsp", 32'(rsp_valid), 32'd0);
`else
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        chk("post_reset_halt_req", 32'(core_halt_req), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
